// File: rtl/cla_tb_pkg.sv
// Shared types for the carry-lookahead adder self-test checker.
package cla_tb_pkg;

  localparam int WIDTH = 4;
  localparam int VEC_W = 2*WIDTH+1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [WIDTH:0]   exp;
    logic [VEC_W-1:0] vec;
  } exp_entry_t;

  // Full-width reference sum of a packed {cin,y,x} vector, carry included.
  function automatic logic [WIDTH:0] calc_exp(input logic [VEC_W-1:0] v);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    a = v[WIDTH-1:0];
    b = v[2*WIDTH-1:WIDTH];
    c = v[2*WIDTH];
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
  endfunction

endpackage

// File: rtl/exp_delay_line.sv
// Delays expected-result entries by LATENCY cycles to line up with the adder output.
module exp_delay_line
  import cla_tb_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       res,
  input  exp_entry_t entry_in,
  output exp_entry_t tail
);

  exp_entry_t stage [LATENCY];

  // Shift register; reset drops every in-flight entry so a discarded sweep leaves no stale compares.
  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= entry_in;
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign tail = stage[LATENCY-1];

endmodule

// File: rtl/cla_stim_checker.sv
// Exhaustive stimulus driver and result checker for the registered CLA adder.
//
// state | meaning
// IDLE  | waiting for start, operands held at 0
// DRIVE | presenting one {cin,y,x} vector per cycle
// DRAIN | operands at 0, letting the last LATENCY results arrive
// DONE  | sweep complete, status held until the next start
//
// WIDTH must equal cla_tb_pkg::WIDTH, since the expected-entry struct is sized by the package.
module cla_stim_checker #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               res,
  input  logic               start,
  output logic [WIDTH:1]     x,
  output logic [WIDTH:1]     y,
  output logic               cin,
  input  logic [WIDTH:1]     z,
  input  logic               cout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_count,
  output logic [2*WIDTH:0]   fail_vec
);

  import cla_tb_pkg::*;

  localparam int VW = 2*WIDTH+1;
  localparam logic [VW-1:0] VEC_LAST = '1;

  state_t        state;
  logic [VW-1:0] vec;
  logic [3:0]    drain_cnt;
  exp_entry_t    push_entry;
  exp_entry_t    tail;
  logic          mismatch;
  logic          restart;

  assign restart = start && ((state == IDLE) || (state == DONE));

  // Entry for the vector currently on the adder inputs; only DRIVE cycles carry a valid compare.
  always_comb begin
    push_entry       = '0;
    push_entry.valid = (state == DRIVE);
    push_entry.exp   = calc_exp(vec);
    push_entry.vec   = vec;
  end

  exp_delay_line #(
    .LATENCY (LATENCY)
  ) u_delay (
    .clk      (clk),
    .res      (res),
    .entry_in (push_entry),
    .tail     (tail)
  );

  assign mismatch = tail.valid && ({cout, z} != tail.exp);

  // Sweep sequencer: operands are registered copies of the vector counter.
  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      vec       <= '0;
      x         <= '0;
      y         <= '0;
      cin       <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= DRIVE;
            vec           <= '0;
            {cin, y, x}   <= '0;
          end
        end
        DRIVE: begin
          if (vec == VEC_LAST) begin
            state       <= DRAIN;
            {cin, y, x} <= '0;
            drain_cnt   <= 4'(LATENCY-1);
          end else begin
            vec         <= vec + 1'b1;
            {cin, y, x} <= vec + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= DONE;
          else drain_cnt <= drain_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Error counter saturates; the first mismatch of a sweep is latched since err_count is still 0 then.
  always_ff @(posedge clk) begin
    if (res) begin
      err_count <= '0;
      fail_vec  <= '0;
    end else if (restart) begin
      err_count <= '0;
      fail_vec  <= '0;
    end else if (mismatch) begin
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      if (err_count == 16'd0) fail_vec <= tail.vec;
    end
  end

  assign busy = (state == DRIVE) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_count == 16'd0);

endmodule

// File: doc/cla_stim_checker.md
# cla_stim_checker

Self-checking, synthesizable stimulus driver and result checker for the registered carry-lookahead adder top level. It drives `x`, `y` and `cin` into the adder and consumes the adder's `z` and `cout`. It sweeps every operand combination exhaustively and compares each result against an internally computed expected sum, delayed to match the adder's pipeline latency. It sits beside the adder in on-chip self-test builds and reports pass/fail plus first-failure details.

## Interface
- `WIDTH`, 4: operand width; operand buses are indexed `[WIDTH:1]`.
- `LATENCY`, 1: cycles from operands driven to result valid at `z`/`cout`; legal range 1..8.
- `clk` in 1: single clock; all logic on rising edge.
- `res` in 1: reset, synchronous, active-high.
- `start` in 1: begin a sweep; sampled only in IDLE or DONE.
- `x` out WIDTH: operand A to adder.
- `y` out WIDTH: operand B to adder.
- `cin` out 1: carry-in to adder.
- `z` in WIDTH: adder sum.
- `cout` in 1: adder carry-out.
- `busy` out 1: high in DRIVE and DRAIN.
- `done` out 1: high in DONE.
- `pass` out 1: `done` and `err_count==0`.
- `err_count` out 16: number of mismatching vectors, saturating at 16'hFFFF.
- `fail_vec` out 2*WIDTH+1: `{cin,y,x}` of the first mismatch; 0 if none.

## Operation
- Vector counter `vec[2*WIDTH:0]` maps to `{cin,y,x}`, with `x` in the LSBs. The sweep runs 0 to 2^(2*WIDTH+1)-1, which is 512 vectors for WIDTH=4.
- Expected value: `{cout,z}` = `x + y + cin`, computed WIDTH+1 bits wide with no truncation.
- States:
  - IDLE: outputs 0. On `start`, go to DRIVE; clear `vec`, `err_count`, `fail_vec`.
  - DRIVE: present vector `vec` and push `{valid=1, expected, vec}` into the delay line. On the last vector, go to DRAIN; otherwise increment `vec`.
  - DRAIN: `x`/`y`/`cin` return to 0; push `valid=0`. After LATENCY cycles, go to DONE.
  - DONE: hold all status. On `start`, restart exactly as from IDLE.
- Compare: every cycle, the delay-line tail is checked. If tail valid and `{cout,z}` != tail expected:
  - increment `err_count`, saturating;
  - if this is the first error of the sweep, latch the tail vector into `fail_vec`.
- `start` in DRIVE or DRAIN is ignored.
- `res` at any time: state goes to IDLE, every output goes to 0, the delay line is cleared (all valid=0), and the sweep in progress is discarded.

## Timing
- Reset values: `x`, `y`, `cin`, `busy`, `done`, `pass`, `err_count` and `fail_vec` are all 0.
- `start` sampled high in IDLE at cycle t:
  - vector k is on `x`/`y`/`cin` during cycle t+1+k;
  - its result is compared during cycle t+1+k+LATENCY.
- N = 2^(2*WIDTH+1) vectors. The last compare is at t+N+LATENCY. `done` rises at t+N+LATENCY+1, with final `err_count` and `fail_vec` visible in the same cycle.
- WIDTH=4, LATENCY=1: `done` at t+514. `busy` is high t+1..t+513.
- `pass` is combinational from registered `done` and `err_count`; no extra latency.
- `err_count` updates one cycle after the mismatching compare.

## Structure
- Package `cla_tb_pkg`:
  - `WIDTH` default;
  - `VEC_W = 2*WIDTH+1`;
  - state enum {IDLE, DRIVE, DRAIN, DONE};
  - expected-entry struct {valid, exp[WIDTH:0], vec[VEC_W-1:0]}.
- Sub-module `exp_delay_line`: a LATENCY-deep shift register of entries with synchronous clear on `res`.
- Top level holds the FSM, vector counter, comparator, error counter and first-fail latch.

## Test plan
- Ideal adder model (registered, latency 1), WIDTH=4, `start` pulse at cycle t:
  - `busy` t+1..t+513; `done` at t+514;
  - `err_count`=0, `pass`=1, `fail_vec`=0.
- Model with `z[1]` stuck at 0:
  - `err_count`=256 (all odd sums);
  - `fail_vec`=9'b0_0000_0001 (x=1, y=0, cin=0); `pass`=0.
- Model latency 2 with LATENCY=1:
  - `err_count` nonzero;
  - `fail_vec`=9'b0_0000_0001, since vector 1 is compared against vector 0's result.
- `res` asserted while `vec`=100:
  - next cycle: IDLE, all outputs 0;
  - a new `start` yields a clean sweep with `pass`=1.
- `start` re-pulsed during DRIVE: no effect, and `done` still arrives at t+514. `start` in DONE after a failing sweep against the ideal model: `err_count` cleared, and the sweep ends with `pass`=1.
